fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the pipelined ARVI core. Replaces the direct PC→i_cache fetch of the single-cycle datapath.
- Runs ahead of decode: issues sequential PC requests to the instruction memory/cache port and buffers {pc, inst} pairs in a prefetch FIFO of depth FIFO_DEPTH.
- Accepts branch/trap redirects from later stages, flushing buffered and in-flight fetches.

---
 rtl/arvi_fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/arvi_fetch_pkg.sv
// rtl/arvi_fetch_pkg.sv - shared state encodings, constants and entry sizing for the ARVI fetch front end
package arvi_fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FETCH_IDLE = 2'd0;
  localparam fetch_state_t FETCH_REQ  = 2'd1;
  localparam fetch_state_t FETCH_DROP = 2'd2;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

  // Each prefetch entry carries {pc, inst}, plus a misaligned flag when that option is built in.
  function automatic int fetch_entry_width(input int xlen, input bit misalign_en);
    return 2 * xlen + (misalign_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO with push, pop, flush and occupancy count
// Head data comes straight from registered storage; flush only resets pointers and count.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (i_push) begin
        mem_q[wr_ptr_q] <= i_push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (i_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - ARVI instruction-fetch front end: PC sequencing, redirect handling, prefetch FIFO
// Optional misaligned-fetch reporting is enabled by defining ARVI_FETCH_MISALIGN_EXC_EN.
module fetch_unit
  import arvi_fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] PC_RESET   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  output logic                        o_mem_req,
  output logic [XLEN-1:0]             o_mem_addr,
  input  logic [XLEN-1:0]             i_mem_data,
  input  logic                        i_mem_ready,
  input  logic                        i_redirect,
  input  logic [XLEN-1:0]             i_redirect_pc,
  output logic                        o_valid,
  output logic [XLEN-1:0]             o_inst,
  output logic [XLEN-1:0]             o_pc,
  input  logic                        i_ready,
`ifdef ARVI_FETCH_MISALIGN_EXC_EN
  output logic                        o_misaligned,
`endif
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

`ifdef ARVI_FETCH_MISALIGN_EXC_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  localparam int EW = fetch_entry_width(XLEN, MIS_EN);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] redirect_tgt, launch_pc, pc_plus4, push_inst;
  logic            launch_mis;
  logic            push, pop, flush;
  logic [EW-1:0]   push_data, head;
  logic [CW-1:0]   count, after_pop;
  logic            space_now, space_next;
`ifdef ARVI_FETCH_MISALIGN_EXC_EN
  logic            stall_q, stall_d;
  logic            push_mis;
`endif

`ifdef ARVI_FETCH_MISALIGN_EXC_EN
  assign redirect_tgt = i_redirect_pc;
  assign launch_mis   = (launch_pc[1:0] != 2'b00);
`else
  assign redirect_tgt = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign launch_mis   = 1'b0;
`endif

  // The address a new request would use: redirect target if one arrives, else the running PC.
  assign launch_pc  = i_redirect ? redirect_tgt : fetch_pc_q;
  assign pc_plus4   = fetch_pc_q + XLEN'(4);
  assign pop        = o_valid && i_ready && !i_redirect;
  assign after_pop  = count - CW'(pop);
  assign space_now  = after_pop < CW'(FIFO_DEPTH);
  assign space_next = (after_pop + CW'(1)) < CW'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    push_inst  = i_mem_data;
`ifdef ARVI_FETCH_MISALIGN_EXC_EN
    stall_d    = stall_q;
    push_mis   = 1'b0;
`endif
    if (i_redirect) begin
      flush      = 1'b1;
      fetch_pc_d = redirect_tgt;
`ifdef ARVI_FETCH_MISALIGN_EXC_EN
      stall_d    = 1'b0;
`endif
    end
    case (state_q)
      FETCH_IDLE: begin
        if (i_redirect || space_now) begin
          if (!launch_mis) begin
            state_d = FETCH_REQ;
            addr_d  = launch_pc;
          end
`ifdef ARVI_FETCH_MISALIGN_EXC_EN
          else if (!i_redirect && !stall_q) begin
            push      = 1'b1;
            push_mis  = 1'b1;
            push_inst = XLEN'(FETCH_NOP);
            stall_d   = 1'b1;
          end
`endif
        end
      end
      FETCH_REQ: begin
        if (i_redirect) begin
          if (i_mem_ready) begin
            state_d = launch_mis ? FETCH_IDLE : FETCH_REQ;
            addr_d  = launch_pc;
          end else begin
            state_d = FETCH_DROP;
          end
        end else if (i_mem_ready) begin
          push       = 1'b1;
          fetch_pc_d = pc_plus4;
          if (space_next) begin
            addr_d = pc_plus4;
          end else begin
            state_d = FETCH_IDLE;
          end
        end
      end
      FETCH_DROP: begin
        // The abandoned request must still complete before a new one may be issued.
        if (i_mem_ready) begin
          state_d = launch_mis ? FETCH_IDLE : FETCH_REQ;
          addr_d  = launch_pc;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

`ifdef ARVI_FETCH_MISALIGN_EXC_EN
  assign push_data = {push_mis, fetch_pc_q, push_inst};
`else
  assign push_data = {fetch_pc_q, push_inst};
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= PC_RESET;
      addr_q     <= PC_RESET;
`ifdef ARVI_FETCH_MISALIGN_EXC_EN
      stall_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
`ifdef ARVI_FETCH_MISALIGN_EXC_EN
      stall_q    <= stall_d;
`endif
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_push_data (push_data),
    .i_pop       (pop),
    .i_flush     (flush),
    .o_head      (head),
    .o_count     (count)
  );

  assign o_mem_req  = (state_q != FETCH_IDLE);
  assign o_mem_addr = addr_q;
  assign o_valid    = (count != '0);
  assign o_inst     = head[XLEN-1:0];
  assign o_pc       = head[2*XLEN-1:XLEN];
  assign o_count    = count;
`ifdef ARVI_FETCH_MISALIGN_EXC_EN
  assign o_misaligned = head[EW-1];
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit (FIFO_DEPTH=4, PC_RESET=0)
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] i_mem_data;
  logic        i_mem_ready;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        i_ready;
  logic [2:0]  o_count;
`ifdef ARVI_FETCH_MISALIGN_EXC_EN
  logic        o_misaligned;
`endif

  fetch_unit #(
    .XLEN       (32),
    .PC_RESET   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_data    (i_mem_data),
    .i_mem_ready   (i_mem_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_valid       (o_valid),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .i_ready       (i_ready),
`ifdef ARVI_FETCH_MISALIGN_EXC_EN
    .o_misaligned  (o_misaligned),
`endif
    .o_count       (o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mr;
    logic [31:0] md;
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
    logic [2:0]  cnt;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[$];
  vec_t v;

  // Memory returns a word derived from its address so a misrouted word is visible.
  function automatic logic [31:0] d(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic mr, input logic [31:0] mdpc, input logic rd,
                              input logic [31:0] rpc, input logic rdy, input logic req,
                              input logic [31:0] addr, input logic valid,
                              input logic [31:0] pc, input logic [2:0] cnt);
    vec_t r;
    r.mr = mr; r.md = d(mdpc); r.rd = rd; r.rpc = rpc; r.rdy = rdy;
    r.req = req; r.addr = addr; r.valid = valid; r.pc = pc; r.inst = d(pc);
    r.mis = 1'b0; r.cnt = cnt;
    return r;
  endfunction

  task automatic apply(input vec_t x, input string name);
    bit ok;
    i_mem_ready   = x.mr;
    i_mem_data    = x.md;
    i_redirect    = x.rd;
    i_redirect_pc = x.rpc;
    i_ready       = x.rdy;
    @(negedge clk);
    ok = (o_mem_req === x.req) && (o_valid === x.valid) && (o_count === x.cnt);
    if (x.req) ok &= (o_mem_addr === x.addr);
    if (x.valid) ok &= (o_pc === x.pc) && (o_inst === x.inst);
`ifdef ARVI_FETCH_MISALIGN_EXC_EN
    if (x.valid) ok &= (o_misaligned === x.mis);
`endif
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got req=%0b addr=%h valid=%0b pc=%h inst=%h count=%0d, expected req=%0b addr=%h valid=%0b pc=%h inst=%h count=%0d",
               name, o_mem_req, o_mem_addr, o_valid, o_pc, o_inst, o_count,
               x.req, x.addr, x.valid, x.pc, x.inst, x.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"},   {31'd0, o_mem_req}, 32'd0);
    chk({tag, "_addr"},  o_mem_addr, 32'd0);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, "_inst"},  o_inst, 32'd0);
    chk({tag, "_pc"},    o_pc, 32'd0);
    chk({tag, "_count"}, {29'd0, o_count}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_mem_ready = 1'b0; i_mem_data = '0; i_redirect = 1'b0; i_redirect_pc = '0; i_ready = 1'b0;

    //           mr mdpc      rd rpc rdy  req addr      v  pc        cnt
    tbl.push_back(mk(0, 32'h00, 0, 0, 0,  0, 32'h00, 0, 32'h00, 0));
    tbl.push_back(mk(1, 32'h00, 0, 0, 0,  1, 32'h00, 0, 32'h00, 0));
    tbl.push_back(mk(1, 32'h04, 0, 0, 0,  1, 32'h04, 1, 32'h00, 1));
    tbl.push_back(mk(1, 32'h08, 0, 0, 0,  1, 32'h08, 1, 32'h00, 2));
    tbl.push_back(mk(1, 32'h0C, 0, 0, 0,  1, 32'h0C, 1, 32'h00, 3));
    tbl.push_back(mk(0, 32'h00, 0, 0, 0,  0, 32'h00, 1, 32'h00, 4));
    tbl.push_back(mk(0, 32'h00, 0, 0, 0,  0, 32'h00, 1, 32'h00, 4));
    tbl.push_back(mk(0, 32'h00, 0, 0, 1,  0, 32'h00, 1, 32'h00, 4));
    tbl.push_back(mk(1, 32'h10, 0, 0, 1,  1, 32'h10, 1, 32'h04, 3));
    tbl.push_back(mk(1, 32'h14, 0, 0, 1,  1, 32'h14, 1, 32'h08, 3));
    tbl.push_back(mk(1, 32'h18, 0, 0, 1,  1, 32'h18, 1, 32'h0C, 3));
    tbl.push_back(mk(1, 32'h1C, 0, 0, 1,  1, 32'h1C, 1, 32'h10, 3));
    tbl.push_back(mk(0, 32'h00, 0, 0, 0,  1, 32'h20, 1, 32'h14, 3));

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Redirect while the request to 0x20 is outstanding; its data arrives three cycles later.
    apply(mk(0, 32'h000, 1, 32'h100, 1,  1, 32'h020, 1, 32'h014, 3), "drop0");
    apply(mk(0, 32'h000, 0, 0,       1,  1, 32'h020, 0, 32'h000, 0), "drop1");
    apply(mk(0, 32'h000, 0, 0,       1,  1, 32'h020, 0, 32'h000, 0), "drop2");
    apply(mk(1, 32'h020, 0, 0,       1,  1, 32'h020, 0, 32'h000, 0), "drop3");
    apply(mk(1, 32'h100, 0, 0,       1,  1, 32'h100, 0, 32'h000, 0), "drop4");
    apply(mk(0, 32'h000, 0, 0,       1,  1, 32'h104, 1, 32'h100, 1), "drop5");
    apply(mk(0, 32'h000, 0, 0,       0,  1, 32'h104, 0, 32'h000, 0), "drop6");

    // Redirect coincident with memory completion and an attempted pop.
    apply(mk(1, 32'h104, 0, 0,       0,  1, 32'h104, 0, 32'h000, 0), "coin0");
    apply(mk(1, 32'h108, 1, 32'h200, 1,  1, 32'h108, 1, 32'h104, 1), "coin1");
    apply(mk(0, 32'h000, 0, 0,       1,  1, 32'h200, 0, 32'h000, 0), "coin2");
    apply(mk(1, 32'h200, 0, 0,       0,  1, 32'h200, 0, 32'h000, 0), "coin3");
    apply(mk(0, 32'h000, 0, 0,       1,  1, 32'h204, 1, 32'h200, 1), "coin4");

    // PC wrap past the top of the address space.
    apply(mk(0, 32'h000,      1, 32'hFFFF_FFFC, 0,  1, 32'h204,      0, 32'h0,        0), "wrap0");
    apply(mk(1, 32'h204,      0, 0,             0,  1, 32'h204,      0, 32'h0,        0), "wrap1");
    apply(mk(1, 32'hFFFF_FFFC, 0, 0,            0,  1, 32'hFFFF_FFFC, 0, 32'h0,       0), "wrap2");
    apply(mk(1, 32'h000,      0, 0,             0,  1, 32'h000,      1, 32'hFFFF_FFFC, 1), "wrap3");
    apply(mk(0, 32'h000,      0, 0,             1,  1, 32'h004,      1, 32'hFFFF_FFFC, 2), "wrap4");
    apply(mk(0, 32'h000,      0, 0,             1,  1, 32'h004,      1, 32'h000,      1), "wrap5");
    apply(mk(0, 32'h000,      0, 0,             0,  1, 32'h004,      0, 32'h000,      0), "wrap6");

`ifdef ARVI_FETCH_MISALIGN_EXC_EN
    apply(mk(1, 32'h004, 1, 32'h102, 0,  1, 32'h004, 0, 32'h0, 0), "mis0");
    apply(mk(0, 32'h000, 0, 0,       0,  0, 32'h000, 0, 32'h0, 0), "mis1");
    v = mk(0, 32'h000, 0, 0, 0,  0, 32'h000, 1, 32'h102, 1);
    v.inst = 32'h0000_0013; v.mis = 1'b1;
    apply(v, "mis2");
    apply(v, "mis3");
    v.rd = 1'b1; v.rpc = 32'h200; v.rdy = 1'b1;
    apply(v, "mis4");
    apply(mk(0, 32'h000, 0, 0,       0,  1, 32'h200, 0, 32'h0, 0), "mis5");
`else
    // Low address bits of a redirect target are dropped.
    apply(mk(1, 32'h004, 1, 32'h302, 0,  1, 32'h004, 0, 32'h0, 0), "align0");
    apply(mk(0, 32'h000, 0, 0,       0,  1, 32'h300, 0, 32'h0, 0), "align1");
`endif

    // Asynchronous reset in the middle of an outstanding request, between clock edges.
    i_mem_ready = 1'b0; i_redirect = 1'b0; i_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(mk(0, 32'h000, 0, 0, 0,  0, 32'h000, 0, 32'h0, 0), "rel0");
    apply(mk(0, 32'h000, 0, 0, 0,  1, 32'h000, 0, 32'h0, 0), "rel1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
